// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, press/release FSM, strobes,
// debounced level and wrapping press counter per key. Define KEY_LONG_PRESS_EN for long-press strobes.
module key_debounce_multi #(
   parameter int NUM_KEYS     = 4,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int ACTIVE_LOW   = 1,
   parameter int CNT_BITS     = 4,
   parameter int LONG_CYC     = 50_000_000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_KEYS-1:0]          key_in,
   output logic [NUM_KEYS-1:0]          key_level,
   output logic [NUM_KEYS-1:0]          press_pulse,
   output logic [NUM_KEYS-1:0]          release_pulse,
   output logic [NUM_KEYS*CNT_BITS-1:0] press_cnt,
   output logic [NUM_KEYS-1:0]          long_pulse
);

`ifdef KEY_LONG_PRESS_EN
   localparam int CW = $clog2(LONG_CYC + 1);
`else
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
`endif

   localparam logic [CW-1:0]       DB_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [NUM_KEYS-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      REL_STABLE,
      PRESS_WAIT,
      PRS_STABLE,
      REL_WAIT
   } state_t;

   if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_param
      $error("key_debounce_multi: illegal parameter set");
   end

   logic [NUM_KEYS-1:0] r_sync_meta;
   logic [NUM_KEYS-1:0] r_sync;

   // Synchronisers idle at the released level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_meta <= REL_LVL;
         r_sync      <= REL_LVL;
      end else begin
         // NOTE: non-blocking so r_sync takes the old r_sync_meta, giving two real flop stages.
         r_sync_meta <= key_in;
         r_sync      <= r_sync_meta;
      end
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      state_t              r_state, w_state_nxt;
      logic [CW-1:0]       r_cnt, w_cnt_nxt;
      logic [CNT_BITS-1:0] r_pcnt, w_pcnt_nxt;
      logic                r_level, w_level_nxt;
      logic                r_press, w_press_nxt;
      logic                r_rel, w_rel_nxt;
      logic                r_long, w_long_nxt;
      logic                w_p;

      assign w_p = (ACTIVE_LOW != 0) ? ~r_sync[g] : r_sync[g];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= REL_STABLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_long  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_level <= w_level_nxt;
            r_press <= w_press_nxt;
            r_rel   <= w_rel_nxt;
            r_long  <= w_long_nxt;
         end
      end

      always_comb begin
         // NOTE: every output gets a default first so no path through the case infers a latch.
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_pcnt_nxt  = r_pcnt;
         w_level_nxt = r_level;
         w_press_nxt = 1'b0;
         w_rel_nxt   = 1'b0;
         w_long_nxt  = 1'b0;
         unique case (r_state)
            REL_STABLE: begin
               if (w_p) begin
                  w_state_nxt = PRESS_WAIT;
                  w_cnt_nxt   = CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!w_p) begin
                  w_state_nxt = REL_STABLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == DB_LAST) begin
                  w_state_nxt = PRS_STABLE;
                  w_cnt_nxt   = '0;
                  w_press_nxt = 1'b1;
                  w_level_nxt = 1'b1;
                  w_pcnt_nxt  = r_pcnt + CNT_BITS'(1);
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            PRS_STABLE: begin
               if (!w_p) begin
                  w_state_nxt = REL_WAIT;
                  w_cnt_nxt   = CW'(1);
               end
`ifdef KEY_LONG_PRESS_EN
               // Count up to LONG_CYC-1 and hold there: one long strobe per press.
               else if (r_cnt < CW'(LONG_CYC - 1)) begin
                  w_cnt_nxt  = r_cnt + CW'(1);
                  w_long_nxt = (r_cnt == CW'(LONG_CYC - 2));
               end
`endif
            end
            REL_WAIT: begin
               if (w_p) begin
                  w_state_nxt = PRS_STABLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == DB_LAST) begin
                  w_state_nxt = REL_STABLE;
                  w_cnt_nxt   = '0;
                  w_rel_nxt   = 1'b1;
                  w_level_nxt = 1'b0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = REL_STABLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      assign key_level[g]                       = r_level;
      assign press_pulse[g]                     = r_press;
      assign release_pulse[g]                   = r_rel;
      assign long_pulse[g]                      = r_long;
      assign press_cnt[g*CNT_BITS +: CNT_BITS] = r_pcnt;
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them whenever a strobe appears.
module tb_key_debounce_multi;

   localparam int NK = 4;
   localparam int DB = 8;
   localparam int CB = 4;
   localparam int LC = 20;
   localparam int LAT = DB + 2;

   typedef enum int {EV_PRESS, EV_REL, EV_LONG} ev_kind_t;
   typedef struct {
      int       cyc;
      int       key;
      ev_kind_t kind;
      int       cnt;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NK-1:0]     key_in;
   logic [NK-1:0]     key_level, press_pulse, release_pulse, long_pulse;
   logic [NK*CB-1:0]  press_cnt;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   ev_t sb[$];
   int  model_cnt[NK];

   key_debounce_multi #(
      .NUM_KEYS(NK), .DEBOUNCE_CYC(DB), .ACTIVE_LOW(1), .CNT_BITS(CB), .LONG_CYC(LC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .press_cnt(press_cnt), .long_pulse(long_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input int k, input ev_kind_t kind);
      ev_t e;
      e.cyc  = c;
      e.key  = k;
      e.kind = kind;
      e.cnt  = 0;
      if (kind == EV_PRESS) begin
         model_cnt[k] = (model_cnt[k] + 1) % (1 << CB);
         e.cnt = model_cnt[k];
      end
      sb.push_back(e);
   endtask

   // Press from the current negedge: press strobe LAT edges later (+ long strobe when enabled).
   task automatic press(input int k);
      key_in[k] = 1'b0;
      push(cyc + LAT, k, EV_PRESS);
   endtask

   task automatic release_key(input int k);
      key_in[k] = 1'b1;
      push(cyc + LAT, k, EV_REL);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic handle(input int k, input ev_kind_t kind);
      ev_t e;
      if (sb.size() == 0) begin
         check($sformatf("unexpected_ev_k%0d_kind%0d", k, kind), 1, 0);
      end else begin
         e = sb.pop_front();
         check("ev_cyc", cyc, e.cyc);
         check("ev_key", k, e.key);
         check("ev_kind", int'(kind), int'(e.kind));
         if (kind == EV_PRESS) begin
            check("press_cnt", int'(press_cnt[k*CB +: CB]), e.cnt);
            check("level_after_press", int'(key_level[k]), 1);
         end else if (kind == EV_REL) begin
            check("level_after_release", int'(key_level[k]), 0);
         end
      end
   endtask

   // Monitor: flags overdue events, then consumes every strobe the DUT shows.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check($sformatf("missed_ev_k%0d_kind%0d_due%0d", sb[0].key, sb[0].kind, sb[0].cyc), 0, 1);
            void'(sb.pop_front());
         end
         for (int k = 0; k < NK; k++) begin
            if (press_pulse[k] && release_pulse[k])
               check($sformatf("strobe_excl_k%0d", k), 1, 0);
            if (press_pulse[k])   handle(k, EV_PRESS);
            if (release_pulse[k]) handle(k, EV_REL);
            if (long_pulse[k])    handle(k, EV_LONG);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_level"}, int'(key_level), 0);
      check({tag, "_press"}, int'(press_pulse), 0);
      check({tag, "_release"}, int'(release_pulse), 0);
      check({tag, "_long"}, int'(long_pulse), 0);
      check({tag, "_cnt"}, int'(press_cnt), 0);
   endtask

   initial begin
      key_in = '1;
      rst_n  = 1'b0;
      for (int k = 0; k < NK; k++) model_cnt[k] = 0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(3);

      // Clean press on key 0 held 50 cycles, then clean release.
      press(0);
`ifdef KEY_LONG_PRESS_EN
      push(cyc + LAT + LC - 1, 0, EV_LONG);
`endif
      idle(50);
      release_key(0);
      idle(15);

      // Key 1: low 5, high 1, then low held: one press counted from the final low.
      key_in[1] = 1'b0;
      idle(5);
      key_in[1] = 1'b1;
      idle(1);
      press(1);
      idle(14);
      release_key(1);
      idle(15);

      // Key 2: release bounce high 3, low 2, high held -> single release strobe.
      press(2);
      idle(14);
      key_in[2] = 1'b1;
      idle(3);
      key_in[2] = 1'b0;
      idle(2);
      release_key(2);
      idle(15);

      // Key 3: 17 clean presses, counter walks 1..15, 0, 1.
      for (int i = 0; i < 17; i++) begin
         press(3);
         idle(12);
         release_key(3);
         idle(12);
      end
      check("key3_cnt_after_17", int'(press_cnt[3*CB +: CB]), 1);

      // Keys 0 and 2 pressed on the same edge.
      press(0);
      press(2);
      idle(12);
      release_key(0);
      release_key(2);
      idle(15);

      // Reset while key 0 is mid-debounce, key kept held through reset.
      key_in[0] = 1'b0;
      idle(5);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      idle(2);
      for (int k = 0; k < NK; k++) model_cnt[k] = 0;
      rst_n = 1'b1;
      push(cyc + LAT, 0, EV_PRESS);
      idle(14);
      release_key(0);
      idle(15);

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
